// File: rtl/enc_pkg.sv
// Shared definitions for the request encoder family: selection modes and
// code-width helper.
package enc_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int N_MIN = 2;
  localparam int N_MAX = 256;

  // Code width for n request lines, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational find-first-set over a vector, starting the search at i_start
// and wrapping modulo N. Reports whether any bit is set and its index.
module prio_find
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] i_vec,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_pos;

  // Rotate the vector so that bit i_start lands at position 0 (modulo N).
  always_comb begin
    w_rot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned j;
      j = i + 32'(i_start);
      if (j >= N) j = j - N;
      w_rot[i] = i_vec[j[W-1:0]];
    end
  end

  // Lowest set position of the rotated vector; scanning downwards lets the
  // lowest hit overwrite any higher one.
  always_comb begin
    w_pos = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (w_rot[i-1]) w_pos = W'(i - 1);
    end
  end

  // Undo the rotation to recover the absolute index.
  always_comb begin
    int unsigned sum;
    o_found = |i_vec;
    sum     = 32'(w_pos) + 32'(i_start);
    if (sum >= N) sum = sum - N;
    o_idx   = W'(sum);
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) request encoder. Request pulses are captured into a
// pending vector; one index per accepted transfer is emitted on a valid/ready
// stream, chosen by fixed priority (lowest index) or round-robin.
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter  int    N    = 8,
  parameter  mode_e MODE = MODE_FIXED,
  localparam int    W    = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  output logic         out_multi,
  output logic [N-1:0] pending
);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("prio_encoder_rr: N=%0d outside legal range 2..256", N);
  end

  logic [N-1:0] r_pending;
  logic         r_valid;
  logic [W-1:0] r_code;
  logic         r_multi;
  logic [W-1:0] r_last;

  logic [N-1:0] w_cand;
  logic [N-1:0] w_onehot;
  logic         w_slot_free;
  logic         w_found;
  logic         w_multi;
  logic [W-1:0] w_start;
  logic [W-1:0] w_grant;

  // Candidate set, free output slot and more-than-one-candidate detect.
  always_comb begin
    w_cand      = r_pending | req;
    w_slot_free = !r_valid || out_ready;
    w_multi     = |(w_cand & (w_cand - N'(1)));
  end

  // Search origin: one past the last grant in round-robin, index 0 otherwise.
  always_comb begin
    w_start = '0;
    if (MODE == MODE_RR) begin
      w_start = (r_last == W'(N - 1)) ? '0 : r_last + 1'b1;
    end
  end

  prio_find #(
    .N(N)
  ) u_find (
    .i_vec   (w_cand),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_grant)
  );

  // One-hot mask of the bit being granted, cleared from pending on grant.
  always_comb begin
    w_onehot = N'(1) << w_grant;
  end

  // Pending vector and output register: grant when the slot is free,
  // otherwise hold the output and keep accumulating requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_code    <= '0;
      r_multi   <= 1'b0;
    end else if (w_slot_free) begin
      if (w_found) begin
        r_code    <= w_grant;
        r_valid   <= 1'b1;
        r_multi   <= w_multi;
        r_pending <= w_cand & ~w_onehot;
      end else begin
        r_valid   <= 1'b0;
        r_pending <= w_cand;
      end
    end else begin
      r_pending <= w_cand;
    end
  end

  // Round-robin pointer: remembers the most recent grant; reset to N-1 so
  // the first search starts at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= W'(N - 1);
    end else if (MODE == MODE_RR && w_slot_free && w_found) begin
      r_last <= w_grant;
    end
  end

  assign out_valid = r_valid;
  assign out_code  = r_code;
  assign out_multi = r_multi;
  assign pending   = r_pending;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed and reference-model checks for prio_encoder_rr across modes and
// several values of N.
module tb_prio_encoder_rr;
  import enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // N=8 fixed priority
  logic [7:0]  fx_req;  logic fx_rdy, fx_vld, fx_multi; logic [2:0] fx_code; logic [7:0]  fx_pend;
  // N=8 round-robin
  logic [7:0]  rr_req;  logic rr_rdy, rr_vld, rr_multi; logic [2:0] rr_code; logic [7:0]  rr_pend;
  // N=2 round-robin
  logic [1:0]  a_req;   logic a_rdy, a_vld, a_multi;    logic [0:0] a_code;  logic [1:0]  a_pend;
  // N=5 fixed priority
  logic [4:0]  b_req;   logic b_rdy, b_vld, b_multi;    logic [2:0] b_code;  logic [4:0]  b_pend;
  // N=16 round-robin
  logic [15:0] c_req;   logic c_rdy, c_vld, c_multi;    logic [3:0] c_code;  logic [15:0] c_pend;

  prio_encoder_rr #(.N(8), .MODE(MODE_FIXED)) u_fx (
    .clk(clk), .rst(rst), .req(fx_req), .out_ready(fx_rdy), .out_valid(fx_vld),
    .out_code(fx_code), .out_multi(fx_multi), .pending(fx_pend));
  prio_encoder_rr #(.N(8), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst(rst), .req(rr_req), .out_ready(rr_rdy), .out_valid(rr_vld),
    .out_code(rr_code), .out_multi(rr_multi), .pending(rr_pend));
  prio_encoder_rr #(.N(2), .MODE(MODE_RR)) u_a (
    .clk(clk), .rst(rst), .req(a_req), .out_ready(a_rdy), .out_valid(a_vld),
    .out_code(a_code), .out_multi(a_multi), .pending(a_pend));
  prio_encoder_rr #(.N(5), .MODE(MODE_FIXED)) u_b (
    .clk(clk), .rst(rst), .req(b_req), .out_ready(b_rdy), .out_valid(b_vld),
    .out_code(b_code), .out_multi(b_multi), .pending(b_pend));
  prio_encoder_rr #(.N(16), .MODE(MODE_RR)) u_c (
    .clk(clk), .rst(rst), .req(c_req), .out_ready(c_rdy), .out_valid(c_vld),
    .out_code(c_code), .out_multi(c_multi), .pending(c_pend));

  typedef struct {
    logic [15:0] pend;
    logic        valid;
    int unsigned code;
    logic        multi;
    int unsigned last;
  } mst_t;

  // Behavioural reference: one clock edge of the encoder for n lines.
  function automatic mst_t mstep(mst_t s, int unsigned n, bit rr, logic [15:0] rq, logic rdy);
    mst_t        t    = s;
    logic [15:0] cand = s.pend | rq;
    int unsigned cnt  = 0;
    bit          hit  = 1'b0;
    int unsigned g    = 0;
    int unsigned idx;
    for (int unsigned i = 0; i < n; i++) if (cand[i[3:0]]) cnt++;
    for (int unsigned i = 0; i < n; i++) begin
      idx = rr ? (s.last + 1 + i) % n : i;
      if (!hit && cand[idx[3:0]]) begin hit = 1'b1; g = idx; end
    end
    if (!s.valid || rdy) begin
      if (hit) begin
        t.valid = 1'b1;
        t.code  = g;
        t.multi = (cnt > 1);
        cand[g[3:0]] = 1'b0;
        t.pend  = cand;
        if (rr) t.last = g;
      end else begin
        t.valid = 1'b0;
        t.pend  = cand;
      end
    end else begin
      t.pend = cand;
    end
    return t;
  endfunction

  function automatic mst_t mreset(int unsigned n);
    mst_t t;
    t.pend = '0; t.valid = 1'b0; t.code = 0; t.multi = 1'b0; t.last = n - 1;
    return t;
  endfunction

  task automatic idle_all();
    fx_req = '0; rr_req = '0; a_req = '0; b_req = '0; c_req = '0;
    fx_rdy = 1'b1; rr_rdy = 1'b1; a_rdy = 1'b1; b_rdy = 1'b1; c_rdy = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] st;
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({fx_vld, fx_multi, fx_code, fx_pend} !== 13'd0) begin
      miscompares++; $display("FAIL reset_fx: got %h want 0", {fx_vld, fx_multi, fx_code, fx_pend});
    end
    vectors++;
    if ({rr_vld, rr_multi, rr_code, rr_pend, c_vld, c_pend} !== 30'd0) begin
      miscompares++; $display("FAIL reset_rr_c: got %h want 0", {rr_vld, rr_multi, rr_code, rr_pend, c_vld, c_pend});
    end
    rst = 1'b0;
    // Build a stall holding pending=A5, then reset asynchronously between edges.
    @(negedge clk); fx_req = 8'h02; fx_rdy = 1'b0;
    @(negedge clk); fx_req = 8'hA5;
    @(negedge clk); fx_req = 8'h00;
    st = {fx_vld, fx_multi, fx_code, fx_pend};
    vectors++;
    if (st !== {1'b1, 1'b0, 3'd1, 8'hA5}) begin
      miscompares++; $display("FAIL reset_prestall: got %h want %h", st, {1'b1, 1'b0, 3'd1, 8'hA5});
    end
    #2 rst = 1'b1;
    #1;
    st = {fx_vld, fx_multi, fx_code, fx_pend};
    vectors++;
    if (st !== 13'd0) begin
      miscompares++; $display("FAIL reset_async: got %h want 0", st);
    end
    #1 rst = 1'b0;
    fx_rdy = 1'b1;
  endtask

  task automatic test_fixed_pair();
    do_reset();
    @(negedge clk); fx_req = 8'b0010_0100;
    @(negedge clk); fx_req = 8'h00;
    vectors++;
    if ({fx_vld, fx_multi, fx_code, fx_pend} !== {1'b1, 1'b1, 3'd2, 8'h20}) begin
      miscompares++; $display("FAIL fixed_first: got %h want %h", {fx_vld, fx_multi, fx_code, fx_pend}, {1'b1, 1'b1, 3'd2, 8'h20});
    end
    @(negedge clk);
    vectors++;
    if ({fx_vld, fx_multi, fx_code, fx_pend} !== {1'b1, 1'b0, 3'd5, 8'h00}) begin
      miscompares++; $display("FAIL fixed_second: got %h want %h", {fx_vld, fx_multi, fx_code, fx_pend}, {1'b1, 1'b0, 3'd5, 8'h00});
    end
    @(negedge clk);
    vectors++;
    if ({fx_vld, fx_code} !== {1'b0, 3'd5}) begin
      miscompares++; $display("FAIL fixed_drain: got vld=%b code=%0d want vld=0 code=5", fx_vld, fx_code);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk); fx_req = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); fx_req = 8'h00;
      vectors++;
      if ({fx_vld, fx_multi, fx_code} !== {1'b1, (i < 7), 3'(i)}) begin
        miscompares++; $display("FAIL b2b_%0d: got vld=%b multi=%b code=%0d want 1 %b %0d", i, fx_vld, fx_multi, fx_code, (i < 7), i);
      end
    end
    @(negedge clk);
    vectors++;
    if (fx_vld !== 1'b0) begin
      miscompares++; $display("FAIL b2b_end: got vld=%b want 0", fx_vld);
    end
  endtask

  task automatic test_hold_rerequest();
    do_reset();
    @(negedge clk); fx_req = 8'h04;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({fx_vld, fx_multi, fx_code, fx_pend} !== {1'b1, 1'b0, 3'd2, 8'h00}) begin
        miscompares++; $display("FAIL hold_%0d: got %h want %h", i, {fx_vld, fx_multi, fx_code, fx_pend}, {1'b1, 1'b0, 3'd2, 8'h00});
      end
    end
    fx_req = 8'h00;
    @(negedge clk);
    vectors++;
    if (fx_vld !== 1'b0) begin
      miscompares++; $display("FAIL hold_end: got vld=%b want 0", fx_vld);
    end
  endtask

  task automatic test_rr_alternate();
    do_reset();
    @(negedge clk); rr_req = 8'h81;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({rr_vld, rr_multi, rr_code} !== {1'b1, 1'b1, ((i % 2) != 0) ? 3'd7 : 3'd0}) begin
        miscompares++; $display("FAIL rr_alt_%0d: got vld=%b multi=%b code=%0d want 1 1 %0d", i, rr_vld, rr_multi, rr_code, ((i % 2) != 0) ? 7 : 0);
      end
    end
    rr_req = 8'h00;
  endtask

  task automatic test_rr_wrap();
    do_reset();
    @(negedge clk); rr_req = 8'h40;
    @(negedge clk); rr_req = 8'h41; rr_rdy = 1'b0;
    vectors++;
    if ({rr_vld, rr_code} !== {1'b1, 3'd6}) begin
      miscompares++; $display("FAIL wrap_setup: got vld=%b code=%0d want 1 6", rr_vld, rr_code);
    end
    @(negedge clk); rr_req = 8'h00;
    vectors++;
    if ({rr_code, rr_pend} !== {3'd6, 8'b0100_0001}) begin
      miscompares++; $display("FAIL wrap_pend: got code=%0d pend=%h want 6 41", rr_code, rr_pend);
    end
    rr_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rr_vld, rr_multi, rr_code, rr_pend} !== {1'b1, 1'b1, 3'd0, 8'h40}) begin
      miscompares++; $display("FAIL wrap_first: got %h want %h", {rr_vld, rr_multi, rr_code, rr_pend}, {1'b1, 1'b1, 3'd0, 8'h40});
    end
    @(negedge clk);
    vectors++;
    if ({rr_vld, rr_multi, rr_code, rr_pend} !== {1'b1, 1'b0, 3'd6, 8'h00}) begin
      miscompares++; $display("FAIL wrap_second: got %h want %h", {rr_vld, rr_multi, rr_code, rr_pend}, {1'b1, 1'b0, 3'd6, 8'h00});
    end
  endtask

  task automatic test_stall();
    logic [7:0] pulses [4] = '{8'h08, 8'h02, 8'h00, 8'h00};
    do_reset();
    @(negedge clk); fx_req = 8'h01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); fx_req = pulses[i]; fx_rdy = 1'b0;
      vectors++;
      if ({fx_vld, fx_code} !== {1'b1, 3'd0}) begin
        miscompares++; $display("FAIL stall_hold_%0d: got vld=%b code=%0d want 1 0", i, fx_vld, fx_code);
      end
    end
    @(negedge clk);
    vectors++;
    if ({fx_vld, fx_code, fx_pend} !== {1'b1, 3'd0, 8'b0000_1010}) begin
      miscompares++; $display("FAIL stall_pend: got vld=%b code=%0d pend=%h want 1 0 0a", fx_vld, fx_code, fx_pend);
    end
    fx_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if ({fx_vld, fx_multi, fx_code} !== {1'b1, 1'b1, 3'd1}) begin
      miscompares++; $display("FAIL stall_g1: got vld=%b multi=%b code=%0d want 1 1 1", fx_vld, fx_multi, fx_code);
    end
    @(negedge clk);
    vectors++;
    if ({fx_vld, fx_multi, fx_code} !== {1'b1, 1'b0, 3'd3}) begin
      miscompares++; $display("FAIL stall_g2: got vld=%b multi=%b code=%0d want 1 0 3", fx_vld, fx_multi, fx_code);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] one;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      one = 16'(1) << k;
      @(negedge clk); a_req = one[1:0]; b_req = one[4:0]; c_req = one;
      @(negedge clk); a_req = '0; b_req = '0; c_req = '0;
      if (k < 2) begin
        vectors++;
        if ({a_vld, a_multi, a_code} !== {1'b1, 1'b0, 1'(k)}) begin
          miscompares++; $display("FAIL sweep_n2_k%0d: got vld=%b multi=%b code=%0d want 1 0 %0d", k, a_vld, a_multi, a_code, k);
        end
      end
      if (k < 5) begin
        vectors++;
        if ({b_vld, b_multi, b_code} !== {1'b1, 1'b0, 3'(k)}) begin
          miscompares++; $display("FAIL sweep_n5_k%0d: got vld=%b multi=%b code=%0d want 1 0 %0d", k, b_vld, b_multi, b_code, k);
        end
      end
      vectors++;
      if ({c_vld, c_multi, c_code} !== {1'b1, 1'b0, 4'(k)}) begin
        miscompares++; $display("FAIL sweep_n16_k%0d: got vld=%b multi=%b code=%0d want 1 0 %0d", k, c_vld, c_multi, c_code, k);
      end
    end
  endtask

  task automatic test_random();
    mst_t ma, mb, mc;
    logic [21:0] act, exp;
    do_reset();
    ma = mreset(2); mb = mreset(5); mc = mreset(16);
    for (int cyc = 0; cyc < 301; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        act = {a_vld, a_multi, 4'(a_code), 16'(a_pend)};
        exp = {ma.valid, ma.multi, 4'(ma.code), ma.pend};
        vectors++;
        if (act !== exp) begin
          miscompares++; $display("FAIL rand_n2_c%0d: got %h want %h", cyc, act, exp);
        end
        act = {b_vld, b_multi, 4'(b_code), 16'(b_pend)};
        exp = {mb.valid, mb.multi, 4'(mb.code), mb.pend};
        vectors++;
        if (act !== exp) begin
          miscompares++; $display("FAIL rand_n5_c%0d: got %h want %h", cyc, act, exp);
        end
        act = {c_vld, c_multi, c_code, c_pend};
        exp = {mc.valid, mc.multi, 4'(mc.code), mc.pend};
        vectors++;
        if (act !== exp) begin
          miscompares++; $display("FAIL rand_n16_c%0d: got %h want %h", cyc, act, exp);
        end
      end
      a_req = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      b_req = 5'($urandom) & 5'($urandom);
      c_req = 16'($urandom) & 16'($urandom) & 16'($urandom);
      a_rdy = ($urandom_range(0, 3) != 0);
      b_rdy = ($urandom_range(0, 3) != 0);
      c_rdy = ($urandom_range(0, 3) != 0);
      ma = mstep(ma, 2, 1'b1, 16'(a_req), a_rdy);
      mb = mstep(mb, 5, 1'b0, 16'(b_req), b_rdy);
      mc = mstep(mc, 16, 1'b1, c_req, c_rdy);
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_fixed_pair();
    test_back_to_back();
    test_hold_rerequest();
    test_rr_alternate();
    test_rr_wrap();
    test_stall();
    test_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
